ifid_fetch_ctrl: RTL and testbench
==================================

# ifid_fetch_ctrl

Fetch sequencer and IF/ID pipeline register for the single-issue RV32I core. It owns the program counter and drives a req/ack handshake to instruction memory. It presents one fetched instruction per accepted cycle to the ID stage, where immediate generation and decode operate on `id_inst`. Stalls are absorbed with a one-entry hold buffer, and flushes redirect the PC, including while a memory request is outstanding.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset. Bits [1:0] must be 0.
- `NOP_INST`, default 32'h0000_0013: `addi x0,x0,0`. Loaded into `id_inst` on reset and flush.

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address. Always word-aligned.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle. Only meaningful while `imem_req`=1.
- `imem_rdata` in 32: fetched instruction word.
- `stall` in 1: ID cannot take a new instruction. The IF/ID register holds.
- `flush` in 1: discard the IF/ID contents and any in-flight fetch, then redirect.
- `redirect_pc` in 32: new PC, sampled when `flush`=1. Bits [1:0] are forced to 0.
- `id_valid` out 1: `id_pc`/`id_inst` hold a real instruction.
- `id_pc` out 32: PC of `id_inst`.
- `id_inst` out 32: instruction to ID.

## Operation
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_pc`=0, `id_inst`=`NOP_INST`, internal `pc`=`RESET_PC`, state=IDLE, hold buffer empty.
- IDLE:
  - `imem_req`=0.
  - Next cycle goes to FETCH, unconditionally.
  - `flush` in IDLE loads `pc` from `redirect_pc`.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`:
  - `flush`=1: drop the data, set `pc`=`redirect_pc`, stay in FETCH. IF/ID is cleared.
  - `stall`=0: load IF/ID with {1, `pc`, `imem_rdata`}, set `pc`=`pc`+4, stay in FETCH.
  - `stall`=1: capture {`pc`, `imem_rdata`} in the hold buffer, set `pc`=`pc`+4, go to HOLD.
  - Without ack, `flush`=1: latch `redirect_pc` into `pend_pc` and go to DROP. `imem_addr` does not change.
  - Without ack, `flush`=0: no change.
- HOLD:
  - `imem_req`=0.
  - `flush`=1: empty the hold buffer, set `pc`=`redirect_pc`, go to FETCH.
  - `stall`=0: move the hold buffer into IF/ID (valid=1) and go to FETCH.
- DROP:
  - `imem_req`=1 with the old address. Handshake rule: req and addr stay stable until ack.
  - On ack: discard the data, set `pc`=`pend_pc`, go to FETCH.
  - A further `flush` overwrites `pend_pc`; the latest redirect wins.
- IF/ID register:
  - `flush` sets `id_valid`=0, `id_inst`=`NOP_INST`, `id_pc`=0.
  - Otherwise, `stall` holds all three.
  - Otherwise, with no new instruction that cycle, `id_valid`=0. `id_inst`/`id_pc` keep their previous values.
- Priority: `rst` > `flush` > `stall` > fetch.
- Arithmetic: `pc`+4 is a 32-bit add that wraps from 32'hFFFF_FFFC to 0. The carry is discarded.

## Timing
- `imem_req`/`imem_addr` are registered outputs.
- The first request is asserted in the 2nd cycle after `rst` deasserts, with `imem_addr`=`RESET_PC`.
- Latency from ack to `id_valid` is one cycle.
- With ack every cycle and no stall, throughput is 1 instruction/cycle and PCs are consecutive.
- Stall then release: the held instruction appears one cycle after `stall` falls. The next request is issued in that same cycle.
- Flush: `id_valid`=0 in the next cycle. The first request to `redirect_pc` is issued next cycle (FETCH/HOLD) or one cycle after the outstanding ack (DROP).
- `rst` asserted mid-transaction abandons the request. `imem_req` is 0 in the next cycle, and instruction memory must tolerate this.

## Structure
- Shared package `core_pkg`:
  - state enum {IDLE, FETCH, HOLD, DROP}
  - `NOP_INST`
  - `RESET_PC` default
  - `XLEN`=32
- Sub-module `ifid_pipe_reg`: the valid/pc/inst register with load, hold and flush controls.
- The FSM, PC and hold buffer stay in the top module.

## Test plan
- Reset with `RESET_PC`=32'h0000_1000 and ack every cycle: `imem_addr` sequence 1000, 1004, 1008. `id_pc` follows one cycle behind the ack with `id_valid`=1, and `id_inst` matches `imem_rdata`.
- Assert `stall` for 3 cycles while an ack arrives at PC 32'h1008: `id_*` holds, `imem_req`=0 during HOLD. After release, `id_pc`=1008, then the next request is 100C. No instruction is lost or duplicated.
- `flush` with `redirect_pc`=32'h0000_2002 in FETCH and no ack: `imem_addr` stays at the old PC until ack, that data is dropped, and the next `imem_addr`=32'h2000.
- `flush` and `stall` together with an ack in the same cycle: `id_valid`=0, `id_inst`=32'h0000_0013, next `imem_addr`=`redirect_pc`.
- `pc`=32'hFFFF_FFFC acked without stall: next `imem_addr`=32'h0000_0000.
- `rst` pulsed while in DROP: the next cycle shows `imem_req`=0 and `id_valid`=0, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end: datapath width,
// reset/NOP constants and the fetch sequencer state encoding.
package core_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- the canonical RV32I no-op.
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // IDLE : one quiet cycle after reset before the first request
    // FETCH: request outstanding for pc
    // HOLD : ID stalled, fetched word parked in the hold buffer
    // DROP : flush arrived while a request was outstanding; wait for its ack
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: valid/pc/inst with flush, hold and load controls.
// Priority is rst > flush > hold > load; without a load the valid bit drops
// while pc/inst keep their last values.
module ifid_pipe_reg #(
    parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;

    // Register update: reset/flush clear to a bubble, hold freezes, else load or bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0000_0000;
            inst_q  <= NOP_INST;
        end else if (!hold) begin
            valid_q <= load;
            if (load) begin
                pc_q   <= load_pc;
                inst_q <= load_inst;
            end
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign inst  = inst_q;

endmodule

// File: rtl/ifid_fetch_ctrl.sv
// Fetch sequencer and IF/ID register for the single-issue RV32I core.
// Owns the PC, drives the imem req/ack handshake, parks one instruction in a
// hold buffer across ID stalls and redirects on flush, even mid-request.
//
// Handshake: imem_req/imem_addr are registered and, once imem_req is high,
// stay stable until the cycle imem_ack is seen high; that cycle completes the
// transfer and imem_rdata is sampled at its closing clock edge. Only rst may
// withdraw a request early.
module ifid_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = core_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [31:0]           imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [31:0]           redirect_pc,
    output logic                  id_valid,
    output logic [31:0]           id_pc,
    output logic [31:0]           id_inst,
    output core_pkg::fetch_state_e dbg_state
);

    import core_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            hold_valid_q, hold_valid_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_inst_q, hold_inst_d;
    logic            req_q;

    logic            ifid_load;
    logic [XLEN-1:0] ifid_load_pc;
    logic [XLEN-1:0] ifid_load_inst;
    logic [XLEN-1:0] redir_pc;

    // Redirect targets are always word aligned.
    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

    // Next-state, PC, hold buffer and IF/ID load selection.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_pc_d      = pend_pc_q;
        hold_valid_d   = hold_valid_q;
        hold_pc_d      = hold_pc_q;
        hold_inst_d    = hold_inst_q;
        ifid_load      = 1'b0;
        ifid_load_pc   = pc_q;
        ifid_load_inst = imem_rdata;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (flush) pc_d = redir_pc;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (flush) begin
                        pc_d = redir_pc;
                    end else if (stall) begin
                        hold_valid_d = 1'b1;
                        hold_pc_d    = pc_q;
                        hold_inst_d  = imem_rdata;
                        pc_d         = pc_q + 32'd4;
                        state_d      = HOLD;
                    end else begin
                        ifid_load = 1'b1;
                        pc_d      = pc_q + 32'd4;
                    end
                end else if (flush) begin
                    // Request must stay up with its old address until acked.
                    pend_pc_d = redir_pc;
                    state_d   = DROP;
                end
            end
            HOLD: begin
                if (flush) begin
                    hold_valid_d = 1'b0;
                    pc_d         = redir_pc;
                    state_d      = FETCH;
                end else if (!stall) begin
                    ifid_load      = hold_valid_q;
                    ifid_load_pc   = hold_pc_q;
                    ifid_load_inst = hold_inst_q;
                    hold_valid_d   = 1'b0;
                    state_d        = FETCH;
                end
            end
            DROP: begin
                // The latest redirect wins, including one coinciding with the ack.
                if (flush) pend_pc_d = redir_pc;
                if (imem_ack) begin
                    pc_d    = flush ? redir_pc : pend_pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC, hold buffer and registered request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            hold_valid_q <= 1'b0;
            hold_pc_q    <= '0;
            hold_inst_q  <= NOP_INST;
            req_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_inst_q  <= hold_inst_d;
            req_q        <= (state_d == FETCH) || (state_d == DROP);
        end
    end

    ifid_pipe_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .hold      (stall),
        .load      (ifid_load),
        .load_pc   (ifid_load_pc),
        .load_inst (ifid_load_inst),
        .valid     (id_valid),
        .pc        (id_pc),
        .inst      (id_inst)
    );

    // In DROP pc_q is untouched, so it still holds the outstanding address.
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ifid_fetch_ctrl.sv
// Directed bench for ifid_fetch_ctrl with RESET_PC = 0x1000. Expected IF/ID
// deliveries are queued by the stimulus thread; a negedge monitor pops one
// whenever ID consumes a valid instruction (no stall, no flush, no reset).
module tb_ifid_fetch_ctrl;

    import core_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    fetch_state_e dbg_state;

    always #5 clk = ~clk;

    ifid_fetch_ctrl #(
        .RESET_PC (32'h0000_1000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: apply inputs, let the edge happen, return 1 time unit after it.
    task automatic cycle(input logic a, input logic s, input logic f, input logic [31:0] rp);
        imem_ack    = a;
        stall       = s;
        flush       = f;
        redirect_pc = rp;
        imem_rdata  = mem_word(imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && id_valid && !stall && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL id_unexpected: got pc=%h inst=%h expected nothing", id_pc, id_inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({id_pc, id_inst} !== e) begin
                    errors++;
                    $display("FAIL id_deliver: got pc=%h inst=%h expected pc=%h inst=%h",
                             id_pc, id_inst, e[63:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",   {31'b0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'h0000_1000);
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_pc",    id_pc, 32'h0);
        check("rst_inst",  id_inst, 32'h0000_0013);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // First request in the 2nd cycle after reset release.
        rst = 1'b0;
        check("idle_req", {31'b0, imem_req}, 32'd0);
        cycle(0, 0, 0, 0);
        check("first_req",  {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0000_1000);

        // Back-to-back acks.
        push_exp(32'h1000);
        cycle(1, 0, 0, 0);
        check("seq_addr1", imem_addr, 32'h0000_1004);
        check("seq_idpc1", id_pc, 32'h0000_1000);
        check("seq_valid1", {31'b0, id_valid}, 32'd1);
        push_exp(32'h1004);
        cycle(1, 0, 0, 0);
        check("seq_addr2", imem_addr, 32'h0000_1008);

        // Ack at 0x1008 under a 3-cycle stall.
        push_exp(32'h1008);
        cycle(1, 1, 0, 0);
        check("hold_req",   {31'b0, imem_req}, 32'd0);
        check("hold_idpc",  id_pc, 32'h0000_1004);
        check("hold_state", 32'(dbg_state), 32'(HOLD));
        cycle(0, 1, 0, 0);
        check("hold_req2",  {31'b0, imem_req}, 32'd0);
        check("hold_idpc2", id_pc, 32'h0000_1004);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        check("rel_idpc",  id_pc, 32'h0000_1008);
        check("rel_valid", {31'b0, id_valid}, 32'd1);
        check("rel_req",   {31'b0, imem_req}, 32'd1);
        check("rel_addr",  imem_addr, 32'h0000_100C);

        push_exp(32'h100C);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("noack_addr",  imem_addr, 32'h0000_1010);
        check("noack_valid", {31'b0, id_valid}, 32'd0);

        // Flush to 0x2002 with the 0x1010 request still outstanding.
        cycle(0, 0, 1, 32'h0000_2002);
        check("drop_state", 32'(dbg_state), 32'(DROP));
        check("drop_addr",  imem_addr, 32'h0000_1010);
        check("drop_req",   {31'b0, imem_req}, 32'd1);
        cycle(0, 0, 0, 0);
        check("drop_addr2", imem_addr, 32'h0000_1010);
        cycle(1, 0, 0, 0);
        check("redir_addr",  imem_addr, 32'h0000_2000);
        check("redir_valid", {31'b0, id_valid}, 32'd0);

        // Flush + stall + ack together.
        push_exp(32'h2000);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 32'h0000_3000);
        check("fsa_valid", {31'b0, id_valid}, 32'd0);
        check("fsa_inst",  id_inst, 32'h0000_0013);
        check("fsa_addr",  imem_addr, 32'h0000_3000);

        // PC wrap at the top of the address space.
        cycle(1, 0, 1, 32'hFFFF_FFFC);
        check("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC);
        cycle(1, 0, 0, 0);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("wrap_idpc", id_pc, 32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        cycle(1, 0, 0, 0);
        check("wrap_addr2", imem_addr, 32'h0000_0004);
        cycle(0, 0, 0, 0);

        // Repeated flush in DROP: latest redirect wins.
        cycle(0, 0, 1, 32'h0000_4000);
        cycle(0, 0, 1, 32'h0000_5000);
        check("drop2_addr", imem_addr, 32'h0000_0004);
        cycle(1, 0, 0, 0);
        check("latest_addr", imem_addr, 32'h0000_5000);

        // Reset while in DROP.
        cycle(0, 0, 1, 32'h0000_6000);
        check("drop3_state", 32'(dbg_state), 32'(DROP));
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        check("mrst_req",   {31'b0, imem_req}, 32'd0);
        check("mrst_valid", {31'b0, id_valid}, 32'd0);
        check("mrst_addr",  imem_addr, 32'h0000_1000);
        rst = 1'b0;
        cycle(0, 0, 0, 0);
        check("restart_req",  {31'b0, imem_req}, 32'd1);
        check("restart_addr", imem_addr, 32'h0000_1000);
        push_exp(32'h1000);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
